serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with a start/ready/done handshake. Operands are added one bit per
// clock cycle, LSB first. The sum is assembled MSB-in in a shift register.

module half_adder_str (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    xor g_s (s, x, y);
    and g_c (c, x, y);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_reg;
    logic             carry_reg, cout_reg;
    logic [CW-1:0]    cnt_reg;
    logic             accept, last_bit;

    // Full-adder cell: two half adders, their carries merged by an OR gate.
    logic ha0_s, ha0_c, bit_s, ha1_c, carry_out;

    half_adder_str u_ha0 (.x(a_sh_reg[0]), .y(b_sh_reg[0]), .s(ha0_s), .c(ha0_c));
    half_adder_str u_ha1 (.x(ha0_s),       .y(carry_reg),   .s(bit_s), .c(ha1_c));
    or g_carry (carry_out, ha0_c, ha1_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last_bit   = (cnt_reg == CW'(WIDTH - 1));
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            sum_reg   <= '0;
        end else if (busy) begin
            a_sh_reg  <= a_sh_reg >> 1;
            b_sh_reg  <= b_sh_reg >> 1;
            sum_reg   <= {bit_s, sum_reg[WIDTH-1:1]};
            carry_reg <= carry_out;
            if (last_bit) begin
                // Counter wraps to 0 so it never leaves 0..WIDTH-1.
                cnt_reg  <= '0;
                cout_reg <= carry_out;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
endmodule
